reg_file_wr_arbiter: RTL and testbench
======================================

Name: reg_file_wr_arbiter

Overview:
- Register file with round-robin write arbitration across multiple clients, each speaking the rf_wr_req/rf_wr_sel/rf_wr_data/rf_wr_ack protocol.
- Sits directly downstream of multi-cycle units such as the integer divider and the main pipeline writeback.
- Commits at most one register write per cycle and returns a one-cycle ack to the winning client.
- Provides two combinational read ports; x0 is hardwired to zero.

Parameters:
- data_width, 32, bits per register.
- num_regs, 32, register count (x0 included).
- num_clients, 2, number of write clients; must be >= 1.
- reg_sel_width, $clog2(num_regs), derived; not overridden.
- client_idx_width, ($clog2(num_clients) > 0 ? $clog2(num_clients) : 1), derived.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous active-low reset.
- wr_req  input  num_clients  bit i: client i requests a write.
- wr_sel  input  num_clients*reg_sel_width  client i selector at bits [i*reg_sel_width +: reg_sel_width].
- wr_data  input  num_clients*data_width  client i data at bits [i*data_width +: data_width].
- wr_ack  output  num_clients  registered; bit i high for one cycle after client i's write commits.
- rd0_sel  input  reg_sel_width  read port 0 selector.
- rd0_data  output  data_width  combinational read data, port 0.
- rd1_sel  input  reg_sel_width  read port 1 selector.
- rd1_data  output  data_width  combinational read data, port 1.

Behaviour:
- Reset (rst low, asynchronous):
  - All registers = 0.
  - wr_ack = 0.
  - Round-robin pointer rr_ptr = 0.
  - In-flight requests are dropped; clients re-request after reset.
- Eligibility: client i is eligible in a cycle iff wr_req[i]=1 and wr_ack[i]=0.
  - The ack mask prevents a double commit, because a client still holds its old request during the ack cycle.
  - A client's next request (e.g. divider modulus after quotient) becomes eligible the cycle after its ack.
- Arbitration (combinational): the winner is the first eligible client searching from rr_ptr upward, wrapping modulo num_clients. No eligible client means no grant.
- Commit on posedge, when a winner exists:
  - regs[wr_sel[winner]] <= wr_data[winner], unless the selector is 0 (x0). An x0 write is still acked but changes no register.
  - wr_ack <= one-hot(winner).
  - rr_ptr <= winner+1, wrapping to 0 at num_clients.
- No winner: wr_ack <= 0; rr_ptr unchanged.
- wr_ack is never high for more than one client, and never high in two consecutive cycles for the same client.
- Latency: a request seen eligible in cycle t commits at the end of cycle t; ack is high in cycle t+1. Sustained throughput is 1 write/cycle aggregate and 1 write per 2 cycles per client.
- Reads:
  - rdN_data = regs[rdN_sel], or 0 when rdN_sel = 0.
  - Reads return the pre-commit value in the commit cycle (no forwarding unless the optional feature is enabled).
- Selector >= num_regs (non-power-of-2 num_regs): write ignored but acked; read returns 0.
- X-checks: assert wr_req is known every cycle; assert the winner's wr_sel and wr_data are known.

Optional Feature:
- Macro: REG_FILE_WR_FORWARD_EN.
- Defined: when a winner exists with nonzero selector equal to rdN_sel, rdN_data returns wr_data[winner] combinationally in that same cycle. x0 still reads 0.
- Undefined: reads reflect only committed register contents.

Test Plan:
- Reset then idle: rd0_sel=5, rd1_sel=0 -> both read 0; wr_ack=0 for 10 cycles.
- Single client 1 (divider) writes x7=0x1234, holds req through the ack cycle -> exactly one commit; wr_ack[1] high only in cycle t+1; x7 reads 0x1234 from t+1.
- Back-to-back divider quotient/modulus: x3=0xFFFFFFFF, then after ack immediately x4=0x5 -> acks in cycles t+1 and t+3; x3 and x4 correct; no duplicate ack.
- Contention: clients 0 and 1 hold continuous requests to x1 and x2 with incrementing data from rr_ptr=0 -> grants alternate 0,1,0,1; each client acked every 2 cycles; no starvation.
- x0 write: client 0 writes sel=0, data=0xDEAD -> ack pulses; rd0_sel=0 reads 0.
- Reset mid-operation: assert rst low in the cycle wr_ack[1]=1 -> ack clears immediately; all registers read 0; rr_ptr=0, so client 0 wins the first post-reset contention.
- With REG_FILE_WR_FORWARD_EN: write x9=0xABCD with rd0_sel=9 -> rd0_data=0xABCD in the commit cycle. Without the macro -> the old value in that cycle.

Source files
------------

// File: rtl/reg_file_wr_arbiter_if.sv
// Write-client and read-port bundle for reg_file_wr_arbiter.
// master = clients/readers, slave = the register file.
interface reg_file_wr_arbiter_if #(
    parameter int data_width  = 32,
    parameter int num_regs    = 32,
    parameter int num_clients = 2
);
    localparam int reg_sel_width = $clog2(num_regs);

    logic [num_clients-1:0]               wr_req;
    logic [num_clients*reg_sel_width-1:0] wr_sel;
    logic [num_clients*data_width-1:0]    wr_data;
    logic [num_clients-1:0]               wr_ack;
    logic [reg_sel_width-1:0]             rd0_sel;
    logic [data_width-1:0]                rd0_data;
    logic [reg_sel_width-1:0]             rd1_sel;
    logic [data_width-1:0]                rd1_data;

    modport master (
        output wr_req, wr_sel, wr_data, rd0_sel, rd1_sel,
        input  wr_ack, rd0_data, rd1_data
    );

    modport slave (
        input  wr_req, wr_sel, wr_data, rd0_sel, rd1_sel,
        output wr_ack, rd0_data, rd1_data
    );
endinterface

// File: rtl/reg_file_wr_arbiter.sv
// Register file with round-robin write arbitration, one commit per cycle, two async read ports.
// Optional macro REG_FILE_WR_FORWARD_EN: forward the committing write to matching read ports.
module reg_file_wr_arbiter #(
    parameter int data_width  = 32,
    parameter int num_regs    = 32,
    parameter int num_clients = 2
) (
    input logic                  clk,
    input logic                  rst,
    reg_file_wr_arbiter_if.slave bus
);
    localparam int reg_sel_width    = $clog2(num_regs);
    localparam int client_idx_width = ($clog2(num_clients) > 0) ? $clog2(num_clients) : 1;

    logic [data_width-1:0]       regs_q [num_regs];
    logic [num_clients-1:0]      ack_q, ack_d;
    logic [client_idx_width-1:0] rr_ptr_q, rr_ptr_d;

    logic [num_clients-1:0]      eligible;
    logic                        grant_valid;
    logic [client_idx_width-1:0] winner;
    logic [reg_sel_width-1:0]    win_sel;
    logic [data_width-1:0]       win_data;
    logic                        win_we;

    logic [reg_sel_width-1:0]    rd_sel  [2];
    logic [data_width-1:0]       rd_data [2];

    function automatic logic sel_in_range(input logic [reg_sel_width-1:0] sel);
        return int'(sel) < num_regs;
    endfunction

    // A client still holds its request during its ack cycle; masking stops a double commit.
    assign eligible = bus.wr_req & ~ack_q;

    // NOTE: every variable driven in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        int unsigned idx;
        grant_valid = 1'b0;
        winner      = '0;
        idx         = 0;
        for (int k = 0; k < num_clients; k++) begin
            idx = (int'(rr_ptr_q) + k) % num_clients;
            if (!grant_valid && eligible[idx]) begin
                grant_valid = 1'b1;
                winner      = client_idx_width'(idx);
            end
        end
    end

    assign win_sel  = bus.wr_sel[winner*reg_sel_width +: reg_sel_width];
    assign win_data = bus.wr_data[winner*data_width +: data_width];
    assign win_we   = grant_valid && (win_sel != '0) && sel_in_range(win_sel);

    always_comb begin
        ack_d    = '0;
        rr_ptr_d = rr_ptr_q;
        if (grant_valid) begin
            ack_d[winner] = 1'b1;
            if (int'(winner) == num_clients - 1) rr_ptr_d = '0;
            else                                 rr_ptr_d = winner + 1'b1;
        end
    end

    // NOTE: the array is reset because every register must read 0 after reset; this keeps it in flops, not RAM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_q    <= '0;
            rr_ptr_q <= '0;
            for (int r = 0; r < num_regs; r++) regs_q[r] <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
            ack_q    <= ack_d;
            rr_ptr_q <= rr_ptr_d;
            if (win_we) regs_q[win_sel] <= win_data;
        end
    end

    assign rd_sel[0] = bus.rd0_sel;
    assign rd_sel[1] = bus.rd1_sel;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data[p] = '0;
            if (rd_sel[p] != '0 && sel_in_range(rd_sel[p])) begin
                rd_data[p] = regs_q[rd_sel[p]];
`ifdef REG_FILE_WR_FORWARD_EN
                if (win_we && win_sel == rd_sel[p]) rd_data[p] = win_data;
`endif
            end
        end
    end

    assign bus.rd0_data = rd_data[0];
    assign bus.rd1_data = rd_data[1];
    assign bus.wr_ack   = ack_q;

`ifndef SYNTHESIS
    a_req_known: assert property (@(posedge clk) disable iff (!rst)
        !$isunknown(bus.wr_req));
    a_winner_known: assert property (@(posedge clk) disable iff (!rst)
        grant_valid |-> !$isunknown({win_sel, win_data}));
    a_ack_onehot0: assert property (@(posedge clk) disable iff (!rst)
        $onehot0(ack_q));
`endif
endmodule

// File: tb/tb_reg_file_wr_arbiter.sv
// Scoreboard bench for reg_file_wr_arbiter: a small arbitration model predicts each commit,
// and the predicted commit is checked against wr_ack and read port 1 when the ack arrives.
module tb_reg_file_wr_arbiter;
    typedef struct {
        int          client;
        logic [4:0]  sel;
        logic [31:0] data;
    } commit_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    commit_t    sb_q[$];
    logic [1:0] m_ack;
    int         m_ptr;

    reg_file_wr_arbiter_if #(.data_width(32), .num_regs(32), .num_clients(2)) bus ();

    reg_file_wr_arbiter #(.data_width(32), .num_regs(32), .num_clients(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_client(input int i, input logic req, input logic [4:0] sel,
                              input logic [31:0] data);
        bus.wr_req[i]          = req;
        bus.wr_sel[i*5 +: 5]   = sel;
        bus.wr_data[i*32 +: 32] = data;
    endtask

    // Predict this cycle's winner, advance one clock, then compare ack and committed data.
    task automatic tick();
        logic [1:0] elig;
        int         w;
        commit_t    c;
        elig = bus.wr_req & ~m_ack;
        w    = -1;
        if (m_ptr == 0) begin
            if (elig[0]) w = 0; else if (elig[1]) w = 1;
        end else begin
            if (elig[1]) w = 1; else if (elig[0]) w = 0;
        end
        if (w >= 0) begin
            c.client = w;
            c.sel    = bus.wr_sel[w*5 +: 5];
            c.data   = bus.wr_data[w*32 +: 32];
            sb_q.push_back(c);
            m_ack = 2'b01 << w;
            m_ptr = (w == 1) ? 0 : 1;
        end else begin
            m_ack = 2'b00;
        end
        @(posedge clk);
        #1;
        check("wr_ack", bus.wr_ack, m_ack);
        if (bus.wr_ack != 2'b00) begin
            check("sb_nonempty", sb_q.size() != 0, 1);
            if (sb_q.size() != 0) begin
                c = sb_q.pop_front();
                bus.rd1_sel = c.sel;
                #1;
                check("commit_data", bus.rd1_data, (c.sel == 5'd0) ? 32'd0 : c.data);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_ack  = 2'b00;
        m_ptr  = 0;
        rst    = 1'b0;
        bus.wr_req  = '0;
        bus.wr_sel  = '0;
        bus.wr_data = '0;
        bus.rd0_sel = 5'd5;
        bus.rd1_sel = 5'd0;

        // Reset then idle
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack", bus.wr_ack, 2'b00);
        rst = 1'b1;
        #1;
        check("idle_rd0", bus.rd0_data, 32'd0);
        check("idle_rd1", bus.rd1_data, 32'd0);
        repeat (10) tick();

        // Single divider write, request held through the ack cycle
        set_client(1, 1'b1, 5'd7, 32'h1234);
        tick();
        check("single_ack", bus.wr_ack, 2'b10);
        bus.rd0_sel = 5'd7;
        #1;
        check("single_rd", bus.rd0_data, 32'h1234);
        tick();
        check("single_no_dup", bus.wr_ack, 2'b00);
        set_client(1, 1'b0, 5'd0, 32'd0);
        tick();

        // Back-to-back quotient / modulus
        set_client(1, 1'b1, 5'd3, 32'hFFFF_FFFF);
        tick();
        check("b2b_ack1", bus.wr_ack, 2'b10);
        set_client(1, 1'b1, 5'd4, 32'h5);
        tick();
        check("b2b_gap", bus.wr_ack, 2'b00);
        tick();
        check("b2b_ack2", bus.wr_ack, 2'b10);
        set_client(1, 1'b0, 5'd0, 32'd0);
        tick();
        check("b2b_no_dup", bus.wr_ack, 2'b00);
        bus.rd0_sel = 5'd3;
        #1;
        check("b2b_x3", bus.rd0_data, 32'hFFFF_FFFF);
        bus.rd0_sel = 5'd4;
        #1;
        check("b2b_x4", bus.rd0_data, 32'h5);

        // Contention from rr_ptr=0: grants alternate 0,1,0,1
        for (int k = 0; k < 8; k++) begin
            set_client(0, 1'b1, 5'd1, 32'h100 + k / 2);
            set_client(1, 1'b1, 5'd2, 32'h200 + k / 2);
            tick();
            check("rr_alt", bus.wr_ack, (k % 2 == 0) ? 2'b01 : 2'b10);
        end
        set_client(0, 1'b0, 5'd0, 32'd0);
        set_client(1, 1'b0, 5'd0, 32'd0);
        tick();
        bus.rd0_sel = 5'd1;
        #1;
        check("rr_x1", bus.rd0_data, 32'h103);
        bus.rd0_sel = 5'd2;
        #1;
        check("rr_x2", bus.rd0_data, 32'h203);

        // x0 write is acked but stores nothing
        set_client(0, 1'b1, 5'd0, 32'hDEAD);
        tick();
        check("x0_ack", bus.wr_ack, 2'b01);
        set_client(0, 1'b0, 5'd0, 32'd0);
        bus.rd0_sel = 5'd0;
        #1;
        check("x0_rd", bus.rd0_data, 32'd0);
        tick();

        // Reset asserted during client 1's ack cycle
        set_client(1, 1'b1, 5'd5, 32'h55);
        tick();
        check("pre_rst_ack", bus.wr_ack, 2'b10);
        rst = 1'b0;
        set_client(1, 1'b0, 5'd0, 32'd0);
        #1;
        check("rst_ack_clear", bus.wr_ack, 2'b00);
        m_ack = 2'b00;
        m_ptr = 0;
        sb_q.delete();
        @(posedge clk);
        #1;
        foreach (bus.wr_ack[i]) check("rst_ack_hold", bus.wr_ack[i], 1'b0);
        for (int s = 1; s < 6; s++) begin
            bus.rd0_sel = 5'(s);
            #1;
            check("rst_regs", bus.rd0_data, 32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        set_client(0, 1'b1, 5'd10, 32'hA);
        set_client(1, 1'b1, 5'd11, 32'hB);
        tick();
        check("post_rst_winner", bus.wr_ack, 2'b01);
        set_client(0, 1'b0, 5'd0, 32'd0);
        tick();
        check("post_rst_second", bus.wr_ack, 2'b10);
        set_client(1, 1'b0, 5'd0, 32'd0);
        tick();

        // Read during the commit cycle: forwarded or old value
        set_client(0, 1'b1, 5'd9, 32'h1111);
        tick();
        set_client(0, 1'b0, 5'd0, 32'd0);
        tick();
        set_client(0, 1'b1, 5'd9, 32'hABCD);
        bus.rd0_sel = 5'd9;
        #1;
`ifdef REG_FILE_WR_FORWARD_EN
        check("commit_cycle_rd", bus.rd0_data, 32'hABCD);
`else
        check("commit_cycle_rd", bus.rd0_data, 32'h1111);
`endif
        tick();
        set_client(0, 1'b0, 5'd0, 32'd0);
        #1;
        check("after_commit_rd", bus.rd0_data, 32'hABCD);
        tick();

        check("sb_drain", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
